alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//   Shares a single combinational 32-bit ALU between two requesters (0 = integer pipe, 1 = address/branch unit).
//   Per-requester valid/ready request and response channels; round-robin grant, operands registered into the ALU.
//   Result and zero flag captured, then held until the granted requester accepts them.
//   Sits between the requesters and the alu instance; drives its a_i/b_i/alu_control_i and reads its result_o/zero_o.
// PARAMETERS
//   WIDTH   32  operand/result width
//   CTRL_W  4   ALU control code width (codes 0-9 valid; others are passed through, ALU returns 0)
// PORTS
//   clk_i            in   1        clock, all state on rising edge
//   rst_ni           in   1        synchronous active-low reset
//   req_valid_i      in   2        requester n presents an operation
//   req_ready_o      out  2        one-hot accept strobe; handshake = valid & ready
//   req_a_i          in   2*WIDTH  operand A, requester n at [n*WIDTH +: WIDTH]
//   req_b_i          in   2*WIDTH  operand B, same packing
//   req_ctrl_i       in   2*CTRL_W ALU control code, same packing
//   rsp_valid_o      out  2        result available for requester n (at most one bit set)
//   rsp_ready_i      in   2        requester n accepts result
//   rsp_result_o     out  WIDTH    captured ALU result (shared bus, qualified by rsp_valid_o)
//   rsp_zero_o       out  1        captured ALU zero flag
//   alu_a_o          out  WIDTH    to ALU operand A (registered)
//   alu_b_o          out  WIDTH    to ALU operand B (registered)
//   alu_ctrl_o       out  CTRL_W   to ALU control (registered)
//   alu_result_i     in   WIDTH    from ALU result
//   alu_zero_i       in   1        from ALU zero flag
//   busy_o           out  1        state != IDLE
//   op_count_o       out  16       completed operations, wraps 0xFFFF -> 0
// BEHAVIOUR
//   FSM: IDLE -> EXEC -> RESP -> IDLE. Reset (rst_ni low at clock edge, any state, even mid-operation):
//   state=IDLE, rr_ptr=0, all alu_* regs=0, rsp_result_o=0, rsp_zero_o=0, op_count_o=0; pending operation dropped.
//   IDLE: req_ready_o combinational, nonzero only here. Grant: if only one valid, grant it; if both,
//     grant requester rr_ptr. On handshake: latch that requester's a/b/ctrl into alu_* regs, record grant id,
//     rr_ptr <= ~grant id, go EXEC. No valid -> stay IDLE, ready=0.
//   EXEC (1 cycle): capture alu_result_i/alu_zero_i into rsp_result_o/rsp_zero_o, go RESP.
//   RESP: rsp_valid_o[grant id]=1. Hold result, zero, alu_* regs stable until rsp_ready_i[grant id]=1;
//     then op_count_o++ and go IDLE. rsp_ready_i of the other requester ignored.
//   Latency: request accepted cycle N -> rsp_valid_o high from cycle N+2. Throughput: one op per >=3 cycles.
//   req_ready_o=0 in EXEC/RESP; requesters keep valid high (operands may change, only sampled at handshake).
//   rr_ptr updates only on grant, so an uncontested requester never flips fairness for the other.
//   Simultaneous valid from both every cycle -> strict alternation 0,1,0,1,...
//   Width: no arithmetic beyond op_count_o modulo 2^16; all data passed unmodified.
// TESTING
//   Reset: hold rst_ni=0 two cycles mid-RESP -> next cycle busy_o=0, rsp_valid_o=00, op_count_o=0, alu_a_o=0.
//   Single op: req0 a=5 b=3 ctrl=6 at cycle N -> rsp_valid_o=01 at N+2, result=2, zero=0; ready held -> count=1.
//   Zero flag: req1 a=7 b=7 ctrl=6 -> rsp_valid_o=10, result=0, zero=1.
//   Contention: both valid continuously, rsp_ready_i=11 -> grants 0,1,0,1; req_ready_o pulses every 3 cycles.
//   Backpressure: rsp_ready_i=00 for 5 cycles in RESP -> rsp_* and alu_* stable, req_ready_o=00, busy_o=1.
//   Wrap: preload 0xFFFF ops (or force) then one op -> op_count_o=0x0000; ctrl=4'd15 -> result 0, zero=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [2*WIDTH-1:0]  req_a_i,
  input  logic [2*WIDTH-1:0]  req_b_i,
  input  logic [2*CTRL_W-1:0] req_ctrl_i,
  output logic [1:0]          rsp_valid_o,
  input  logic [1:0]          rsp_ready_i,
  output logic [WIDTH-1:0]    rsp_result_o,
  output logic                rsp_zero_o,
  output logic [WIDTH-1:0]    alu_a_o,
  output logic [WIDTH-1:0]    alu_b_o,
  output logic [CTRL_W-1:0]   alu_ctrl_o,
  input  logic [WIDTH-1:0]    alu_result_i,
  input  logic                alu_zero_i,
  output logic                busy_o,
  output logic [15:0]         op_count_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic rr_ptr, gid, gnt, take, done;
  always_comb begin
    gnt         = &req_valid_i ? rr_ptr : req_valid_i[1];
    take        = state == IDLE && |req_valid_i;
    done        = state == RESP && rsp_ready_i[gid];
    req_ready_o = take ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid_o = state == RESP ? (gid ? 2'b10 : 2'b01) : 2'b00;
    busy_o      = state != IDLE;
    state_nxt   = take ? EXEC : state == EXEC ? RESP : done ? IDLE : state;
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  // rr_ptr moves only on a grant, so a lone requester never steals the other's turn
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr       <= 1'b0;
      gid          <= 1'b0;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      alu_ctrl_o   <= '0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      op_count_o   <= '0;
    end else begin
      if (take) begin
        alu_a_o    <= gnt ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
        alu_b_o    <= gnt ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
        alu_ctrl_o <= gnt ? req_ctrl_i[2*CTRL_W-1:CTRL_W] : req_ctrl_i[CTRL_W-1:0];
        gid        <= gnt;
        rr_ptr     <= ~gnt;
      end
      if (state == EXEC) begin
        rsp_result_o <= alu_result_i;
        rsp_zero_o   <= alu_zero_i;
      end
      if (done) op_count_o <= op_count_o + 16'd1;
    end
  end
endmodule
